// File: rtl/regfile_pkg.sv
// Shared constants for the scoreboarded register file.
// Default sizes and RISC-V ABI register indices.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW        = $clog2(NREGS_DEF);

    localparam logic [AW-1:0] ZERO = 5'd0;
    localparam logic [AW-1:0] RA   = 5'd1;
    localparam logic [AW-1:0] SP   = 5'd2;
    localparam logic [AW-1:0] GP   = 5'd3;
    localparam logic [AW-1:0] TP   = 5'd4;
    localparam logic [AW-1:0] T0   = 5'd5;
    localparam logic [AW-1:0] T1   = 5'd6;
    localparam logic [AW-1:0] T2   = 5'd7;
    localparam logic [AW-1:0] S0   = 5'd8;
    localparam logic [AW-1:0] S1   = 5'd9;
    localparam logic [AW-1:0] A0   = 5'd10;
    localparam logic [AW-1:0] A1   = 5'd11;
    localparam logic [AW-1:0] A2   = 5'd12;
    localparam logic [AW-1:0] A3   = 5'd13;
    localparam logic [AW-1:0] A4   = 5'd14;
    localparam logic [AW-1:0] A5   = 5'd15;
    localparam logic [AW-1:0] A6   = 5'd16;
    localparam logic [AW-1:0] A7   = 5'd17;
    localparam logic [AW-1:0] S2   = 5'd18;
    localparam logic [AW-1:0] S3   = 5'd19;
    localparam logic [AW-1:0] S4   = 5'd20;
    localparam logic [AW-1:0] S5   = 5'd21;
    localparam logic [AW-1:0] S6   = 5'd22;
    localparam logic [AW-1:0] S7   = 5'd23;
    localparam logic [AW-1:0] S8   = 5'd24;
    localparam logic [AW-1:0] S9   = 5'd25;
    localparam logic [AW-1:0] S10  = 5'd26;
    localparam logic [AW-1:0] S11  = 5'd27;
    localparam logic [AW-1:0] T3   = 5'd28;
    localparam logic [AW-1:0] T4   = 5'd29;
    localparam logic [AW-1:0] T5   = 5'd30;
    localparam logic [AW-1:0] T6   = 5'd31;

endpackage

// File: rtl/regfile_sb_multiport_sb_counter.sv
// Pending-writer counter for one architectural register.
// Decrement floors at zero; increments are pre-gated by the stall logic.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             is_zero,
    output logic             at_max
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             dec_ok;

    assign is_zero = (cnt_q == '0);
    assign at_max  = (cnt_q == '1);
    assign dec_ok  = dec && !is_zero;
    assign cnt     = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (flush)
            cnt_d = '0;
        else if (inc && !dec_ok)
            cnt_d = cnt_q + 1'b1;
        else if (dec_ok && !inc)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/regfile_sb_multiport.sv
// Multi-port integer register file with per-register pending-writer
// scoreboard, writeback bypass and flush.
module regfile_sb_multiport
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NUM_RD = 2,
    parameter int CNT_W  = 2,
    localparam int AB    = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_RD-1:0]      rd_en,
    input  logic [NUM_RD*AB-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_rdy,
    input  logic                   wb_we,
    input  logic [AB-1:0]          wb_addr,
    input  logic [XLEN-1:0]        wb_data,
    input  logic                   inv_we,
    input  logic [AB-1:0]          inv_addr,
    output logic                   inv_stall,
    input  logic                   flush,
    output logic                   source_not_ready,
    output logic                   sb_err
);

    logic [XLEN-1:0]        regs_q [NREGS];
    logic [NREGS*CNT_W-1:0] cnt_v;
    logic [NREGS-1:0]       zero_v;
    logic [NREGS-1:0]       max_v;
    logic [NREGS-1:1]       inc_v;
    logic [NREGS-1:1]       dec_v;

    logic [NUM_RD*XLEN-1:0] rd_data_q, rd_data_d;
    logic [NUM_RD-1:0]      rd_rdy_q, rd_rdy_d;
    logic [NUM_RD-1:0]      rd_en_q;
    logic                   sb_err_q, sb_err_d;

    logic [AB-1:0]          ra [NUM_RD];
    logic [NUM_RD-1:0]      hit;
    logic                   wb_on;

    assign wb_on = wb_we && (wb_addr != '0);

    // A same-cycle writeback frees a slot, so a full register may still allocate.
    assign inv_stall = inv_we && (inv_addr != '0) && max_v[inv_addr]
                     && !(wb_we && (wb_addr == inv_addr));

    assign cnt_v[CNT_W-1:0] = '0;
    assign zero_v[0]        = 1'b1;
    assign max_v[0]         = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : g_cnt
        assign inc_v[r] = inv_we && (inv_addr == AB'(r)) && !inv_stall;
        assign dec_v[r] = wb_we && (wb_addr == AB'(r));
        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk     (clk),
            .reset   (reset),
            .flush   (flush),
            .inc     (inc_v[r]),
            .dec     (dec_v[r]),
            .cnt     (cnt_v[r*CNT_W +: CNT_W]),
            .is_zero (zero_v[r]),
            .at_max  (max_v[r])
        );
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_port
        assign ra[i]  = rd_addr[i*AB +: AB];
        assign hit[i] = wb_on && (wb_addr == ra[i]);
    end

    always_comb begin
        rd_data_d = rd_data_q;
        rd_rdy_d  = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (rd_en[i]) begin
                if (ra[i] == '0)
                    rd_data_d[i*XLEN +: XLEN] = '0;
                else if (hit[i])
                    rd_data_d[i*XLEN +: XLEN] = wb_data;
                else
                    rd_data_d[i*XLEN +: XLEN] = regs_q[ra[i]];
                // Pending allocate in this cycle is deliberately not seen.
                rd_rdy_d[i] = flush || zero_v[ra[i]]
                    || (hit[i]
                        && cnt_v[ra[i]*CNT_W +: CNT_W] == CNT_W'(1));
            end
        end
    end

    assign sb_err_d = sb_err_q || (wb_on && zero_v[wb_addr]);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NREGS; k++)
                regs_q[k] <= '0;
            rd_data_q <= '0;
            rd_rdy_q  <= '0;
            rd_en_q   <= '0;
            sb_err_q  <= 1'b0;
        end else begin
            if (wb_on)
                regs_q[wb_addr] <= wb_data;
            rd_data_q <= rd_data_d;
            rd_rdy_q  <= rd_rdy_d;
            rd_en_q   <= rd_en;
            sb_err_q  <= sb_err_d;
        end
    end

    assign rd_data          = rd_data_q;
    assign rd_rdy           = rd_rdy_q;
    assign source_not_ready = |(rd_en_q & ~rd_rdy_q);
    assign sb_err           = sb_err_q;

endmodule

// File: tb/tb_regfile_sb_multiport.sv
// Directed plus random checks of regfile_sb_multiport against an
// array-based reference model of registers and pending counts.
module tb_regfile_sb_multiport;

    localparam int MAXC = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  rd_en;
    logic [4:0]  pa [2];
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_rdy;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        inv_we;
    logic [4:0]  inv_addr;
    logic        inv_stall;
    logic        flush;
    logic        source_not_ready;
    logic        sb_err;

    int n_cmp = 0;
    int n_bad = 0;

    int          m_cnt [32];
    logic [31:0] m_reg [32];
    logic        m_err;
    logic [31:0] e_data [2];
    logic        e_rdy [2];
    logic        e_snr;

    assign rd_addr = {pa[1], pa[0]};

    always #5 clk = ~clk;

    regfile_sb_multiport #(
        .XLEN(32), .NREGS(32), .NUM_RD(2), .CNT_W(2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .rd_en            (rd_en),
        .rd_addr          (rd_addr),
        .rd_data          (rd_data),
        .rd_rdy           (rd_rdy),
        .wb_we            (wb_we),
        .wb_addr          (wb_addr),
        .wb_data          (wb_data),
        .inv_we           (inv_we),
        .inv_addr         (inv_addr),
        .inv_stall        (inv_stall),
        .flush            (flush),
        .source_not_ready (source_not_ready),
        .sb_err           (sb_err)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        reset    = 1'b0;
        rd_en    = 2'b00;
        pa[0]    = 5'd0;
        pa[1]    = 5'd0;
        wb_we    = 1'b0;
        wb_addr  = 5'd0;
        wb_data  = $urandom;
        inv_we   = 1'b0;
        inv_addr = 5'd0;
        flush    = 1'b0;
    endtask

    // One clock: predict from the model, advance, compare.
    task automatic cyc(input string tag);
        logic stall;
        logic hit;
        int   n;
        int   nc [32];
        #1;
        stall = inv_we && inv_addr != 0 && m_cnt[inv_addr] == MAXC
              && !(wb_we && wb_addr == inv_addr);
        chk($sformatf("%s.stall", tag), inv_stall, stall);
        if (reset) begin
            for (int r = 0; r < 32; r++) begin
                m_cnt[r] = 0;
                m_reg[r] = 0;
            end
            m_err = 0;
            e_snr = 0;
            for (int p = 0; p < 2; p++) begin
                e_data[p] = 0;
                e_rdy[p]  = 0;
            end
        end else begin
            e_snr = 0;
            for (int p = 0; p < 2; p++) begin
                e_rdy[p] = 0;
                if (rd_en[p]) begin
                    hit = wb_we && wb_addr == pa[p] && pa[p] != 0;
                    if (pa[p] == 0)
                        e_data[p] = 0;
                    else if (hit)
                        e_data[p] = wb_data;
                    else
                        e_data[p] = m_reg[pa[p]];
                    n = m_cnt[pa[p]];
                    if (hit && n > 0)
                        n = n - 1;
                    e_rdy[p] = pa[p] == 0 || flush || n == 0;
                    if (!e_rdy[p])
                        e_snr = 1;
                end
            end
            if (wb_we && wb_addr != 0 && m_cnt[wb_addr] == 0)
                m_err = 1;
            for (int r = 0; r < 32; r++) begin
                n = m_cnt[r];
                if (r != 0 && !flush) begin
                    if (inv_we && inv_addr == r && !stall)
                        n = n + 1;
                    if (wb_we && wb_addr == r && m_cnt[r] > 0)
                        n = n - 1;
                end
                nc[r] = flush ? 0 : n;
            end
            for (int r = 0; r < 32; r++)
                m_cnt[r] = nc[r];
            if (wb_we && wb_addr != 0)
                m_reg[wb_addr] = wb_data;
        end
        @(posedge clk);
        #1;
        chk($sformatf("%s.data0", tag), rd_data[31:0], e_data[0]);
        chk($sformatf("%s.data1", tag), rd_data[63:32], e_data[1]);
        chk($sformatf("%s.rdy0", tag), rd_rdy[0], e_rdy[0]);
        chk($sformatf("%s.rdy1", tag), rd_rdy[1], e_rdy[1]);
        chk($sformatf("%s.snr", tag), source_not_ready, e_snr);
        chk($sformatf("%s.err", tag), sb_err, m_err);
    endtask

    task automatic rd(input int p, input logic [4:0] a);
        rd_en[p] = 1'b1;
        pa[p]    = a;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_we   = 1'b1;
        wb_addr = a;
        wb_data = d;
    endtask

    task automatic inv(input logic [4:0] a);
        inv_we   = 1'b1;
        inv_addr = a;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        reset = 1'b1;
        cyc("reset");
        chk("reset.data_raw", rd_data, 64'd0);
        chk("reset.rdy_raw", rd_rdy, 64'd0);

        // 1: reads right after reset
        idle(); rd(0, 5'd10); rd(1, 5'd2);
        cyc("t1.read");
        chk("t1.rdy_both", rd_rdy, 64'd3);

        // 2: writeback bypass
        idle(); wb(5'd10, 32'hDEADBEEF); rd(0, 5'd10);
        cyc("t2.bypass");
        chk("t2.data0_lit", rd_data[31:0], 64'hDEADBEEF);

        // 3: saturate a5, drain it
        for (int k = 0; k < 4; k++) begin
            idle(); inv(5'd15);
            cyc($sformatf("t3.inv%0d", k));
        end
        idle(); inv(5'd15);
        #1;
        chk("t3.stall_lit", inv_stall, 64'd1);
        idle(); rd(0, 5'd15);
        cyc("t3.read_busy");
        chk("t3.snr_lit", source_not_ready, 64'd1);
        for (int k = 0; k < 3; k++) begin
            idle(); wb(5'd15, 32'h100 + k); rd(0, 5'd15);
            cyc($sformatf("t3.wb%0d", k));
        end
        chk("t3.rdy_lit", rd_rdy[0], 64'd1);

        // 4: allocate and writeback together at max
        for (int k = 0; k < 3; k++) begin
            idle(); inv(5'd5);
            cyc($sformatf("t4.inv%0d", k));
        end
        idle(); inv(5'd5); wb(5'd5, 32'h55);
        cyc("t4.inv_wb");
        idle(); rd(0, 5'd5); inv(5'd6); rd(1, 5'd6);
        cyc("t4.read");
        chk("t4.rdy_lit", rd_rdy, 64'd2);

        // 5: scoreboard error and x0
        idle(); wb(5'd9, 32'h99);
        cyc("t5.err");
        idle(); wb(5'd0, 32'h5);
        cyc("t5.wbx0");
        idle(); rd(0, 5'd0); rd(1, 5'd9);
        cyc("t5.rdx0");
        chk("t5.err_lit", sb_err, 64'd1);

        // 6: flush and reset-during-flush
        idle(); inv(5'd11);
        cyc("t6.inv1");
        idle(); inv(5'd12);
        cyc("t6.inv2");
        idle(); flush = 1'b1; rd(0, 5'd11); rd(1, 5'd12);
        cyc("t6.flush");
        idle(); rd(0, 5'd11); rd(1, 5'd12);
        cyc("t6.after");
        idle(); inv(5'd11);
        cyc("t6.inv3");
        idle(); flush = 1'b1; reset = 1'b1; wb(5'd11, 32'h77);
        cyc("t6.rstflush");
        idle(); rd(0, 5'd11); rd(1, 5'd12);
        cyc("t6.after_rst");

        // random traffic on a few hot registers
        for (int k = 0; k < 400; k++) begin
            idle();
            rd_en    = 2'($urandom);
            pa[0]    = 5'($urandom_range(0, 7));
            pa[1]    = 5'($urandom_range(0, 7));
            wb_we    = ($urandom_range(0, 2) == 0);
            wb_addr  = 5'($urandom_range(0, 7));
            inv_we   = ($urandom_range(0, 1) == 0);
            inv_addr = 5'($urandom_range(0, 7));
            flush    = ($urandom_range(0, 23) == 0);
            reset    = ($urandom_range(0, 63) == 0);
            cyc($sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
